switch_block_cfg_loader: RTL and testbench

//  Configuration writer for the bidirectional switch-block fabric. Accepts a serial

---
 rtl/switch_block_cfg_loader_if.sv | 34 +++
 rtl/switch_block_cfg_loader.sv | 136 +++++++++++++
 tb/tb_switch_block_cfg_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_block_cfg_loader_if.sv
// Configuration handshake bundle between a frame source and switch_block_cfg_loader.
//   master : frame source (drives cfg_start/cfg_valid/cfg_data, observes status/select)
//   slave  : the loader (drives cfg_ready, select, cfg_done, cfg_error, cfg_loaded)
// Ports carried:
//   cfg_start  frame start strobe
//   cfg_valid  cfg_data valid
//   cfg_data   serial config bit
//   cfg_ready  loader accepts a bit this cycle
//   select     committed switch-block configuration (CFG_BITS wide)
//   cfg_done   one-cycle pulse when a new config is committed
//   cfg_error  sticky, last frame rejected
//   cfg_loaded at least one frame committed since reset
interface switch_block_cfg_loader_if #(
  parameter int CFG_BITS = 108
);
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_data;
  logic                cfg_ready;
  logic [CFG_BITS-1:0] select;
  logic                cfg_done;
  logic                cfg_error;
  logic                cfg_loaded;

  modport master (
    output cfg_start, cfg_valid, cfg_data,
    input  cfg_ready, select, cfg_done, cfg_error, cfg_loaded
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    output cfg_ready, select, cfg_done, cfg_error, cfg_loaded
  );
endinterface

// File: rtl/switch_block_cfg_loader.sv
// Serial configuration loader for one switch block of the bidirectional fabric.
// A frame of CFG_BITS bits is collected into a shadow register; only a complete
// frame is copied to select, in a single cycle, so the switches never see a
// partially written configuration.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (select returns to all-open)
//   cfg    switch_block_cfg_loader_if.slave (handshake, select and status)
// Frame bit k lands in select[k]; switch (x,y) owns select[s+11:s] with
// s = (x + y*WIRE_WIDTH)*SWITCH_BITS.
// Optional feature macro SB_CFG_PARITY_EN: when defined, each frame carries one
// trailing even-parity beat (XOR of all data bits); a mismatch rejects the frame
// and sets the sticky cfg_error instead of committing.
//
// state  | meaning
// IDLE   | waiting for cfg_start, cfg_ready low
// LOAD   | accepting data beats into shadow
// PARITY | accepting the parity beat (SB_CFG_PARITY_EN only)
// COMMIT | first cycle copies shadow to select, second cycle drops cfg_done
module switch_block_cfg_loader #(
  parameter int WIRE_WIDTH  = 3,
  parameter int SWITCH_BITS = 12
) (
  input logic                        clk,
  input logic                        rst_n,
  switch_block_cfg_loader_if.slave   cfg
);
  localparam int CFG_BITS = WIRE_WIDTH * WIRE_WIDTH * SWITCH_BITS;
  localparam int CNT_W    = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_BITS - 1);

`ifdef SB_CFG_PARITY_EN
  typedef enum logic [1:0] {IDLE, LOAD, PARITY, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] select_q;
  logic                ready_q;
  logic                done_q;
  logic                error_q;
  logic                loaded_q;

  logic beat;
  assign beat = cfg.cfg_valid & ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      select_q <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state   <= LOAD;
            cnt     <= '0;
            shadow  <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end

        LOAD: begin
          // A restart wins over a beat presented in the same cycle.
          if (cfg.cfg_start) begin
            cnt    <= '0;
            shadow <= '0;
          end else if (beat) begin
            shadow[cnt] <= cfg.cfg_data;
            if (cnt == LAST_BIT) begin
`ifdef SB_CFG_PARITY_EN
              state   <= PARITY;
`else
              state   <= COMMIT;
              ready_q <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

`ifdef SB_CFG_PARITY_EN
        PARITY: begin
          if (cfg.cfg_start) begin
            state  <= LOAD;
            cnt    <= '0;
            shadow <= '0;
          end else if (beat) begin
            ready_q <= 1'b0;
            if (cfg.cfg_data == ^shadow) begin
              state <= COMMIT;
            end else begin
              error_q <= 1'b1;
              state   <= IDLE;
            end
          end
        end
`endif

        COMMIT: begin
          // Held for two cycles so a cfg_start coinciding with cfg_done is ignored.
          if (!done_q) begin
            select_q <= shadow;
            done_q   <= 1'b1;
            loaded_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.cfg_ready  = ready_q;
  assign cfg.select     = select_q;
  assign cfg.cfg_done   = done_q;
  assign cfg.cfg_error  = error_q;
  assign cfg.cfg_loaded = loaded_q;
endmodule

// File: tb/tb_switch_block_cfg_loader.sv
// Bench for switch_block_cfg_loader: directed frames, aborts, back-to-back,
// async reset and randomized frames, compared every cycle against a
// queue-based model of the frame protocol.
module tb_switch_block_cfg_loader;
  localparam int WIRE_WIDTH  = 3;
  localparam int SWITCH_BITS = 12;
  localparam int CFG_BITS    = WIRE_WIDTH * WIRE_WIDTH * SWITCH_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_block_cfg_loader_if #(.CFG_BITS(CFG_BITS)) cfg_if ();

  switch_block_cfg_loader #(
    .WIRE_WIDTH (WIRE_WIDTH),
    .SWITCH_BITS(SWITCH_BITS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cfg  (cfg_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [CFG_BITS-1:0] act,
                       input logic [CFG_BITS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame bits are collected in a queue; once the frame (plus parity beat when
  // enabled) is complete, select becomes the queue contents two edges later.
  bit                  m_active;
  bit                  q[$];
  int                  m_cd;       // edges left until commit activity is over
  logic [CFG_BITS-1:0] m_select;
  bit                  m_done, m_loaded, m_error, m_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; q.delete(); m_cd = 0; m_select = '0;
      m_done = 0; m_loaded = 0; m_error = 0; m_ready = 0;
    end else if (m_cd == 2) begin
      for (int i = 0; i < CFG_BITS; i++) m_select[i] = q[i];
      m_done = 1; m_loaded = 1; m_cd = 1;
    end else if (m_cd == 1) begin
      m_done = 0; m_cd = 0;
    end else if (!m_active) begin
      if (cfg_if.cfg_start) begin
        m_active = 1; q.delete(); m_error = 0; m_ready = 1;
      end
    end else begin
      if (cfg_if.cfg_start) begin
        q.delete();
      end else if (cfg_if.cfg_valid) begin
        q.push_back(cfg_if.cfg_data);
`ifdef SB_CFG_PARITY_EN
        if (q.size() == CFG_BITS + 1) begin
          bit par;
          par = 0;
          for (int i = 0; i < CFG_BITS; i++) par ^= q[i];
          m_active = 0; m_ready = 0;
          if (par == q[CFG_BITS]) m_cd = 2;
          else m_error = 1;
        end
`else
        if (q.size() == CFG_BITS) begin
          m_active = 0; m_ready = 0; m_cd = 2;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("select", cfg_if.select, m_select);
      check("cfg_ready", CFG_BITS'(cfg_if.cfg_ready), CFG_BITS'(m_ready));
      check("cfg_done", CFG_BITS'(cfg_if.cfg_done), CFG_BITS'(m_done));
      check("cfg_error", CFG_BITS'(cfg_if.cfg_error), CFG_BITS'(m_error));
      check("cfg_loaded", CFG_BITS'(cfg_if.cfg_loaded), CFG_BITS'(m_loaded));
      if (cfg_if.cfg_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit s, input bit v, input bit d);
    cfg_if.cfg_start = s;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_data  = d;
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid held high, 1: valid toggles 1/0, 2: random gaps (gap_pct)
  task automatic send_bits(input logic [CFG_BITS-1:0] f, input int n,
                           input int mode, input int gap_pct);
    int i = 0;
    int k = 0;
    while (i < n && k < 20000) begin
      bit gap;
      gap = (mode == 1) ? (k % 2 == 1) :
            (mode == 2) ? ($urandom_range(0, 99) < gap_pct) : 1'b0;
      if (gap) cyc(0, 0, 1'($urandom_range(0, 1)));
      else begin
        cyc(0, 1, f[i]);
        i++;
      end
      k++;
    end
  endtask

  task automatic send_parity(input logic [CFG_BITS-1:0] f, input bit flip);
`ifdef SB_CFG_PARITY_EN
    cyc(0, 1, (^f) ^ flip);
`else
    if (flip) cyc(0, 0, 0);
`endif
  endtask

  task automatic finish_frame();
    int k = 0;
    while (m_cd != 0 && k < 10) begin
      cyc(0, 0, 0);
      k++;
    end
    check("commit_timeout", CFG_BITS'(m_cd), '0);
    cyc(0, 0, 0);
  endtask

  logic [CFG_BITS-1:0] f_a5c, f_ones, f_alt, f_rnd, f_oth;
  int d0;

  initial begin
    cfg_if.cfg_start = 0;
    cfg_if.cfg_valid = 0;
    cfg_if.cfg_data  = 0;
    f_a5c = '0; f_a5c[11:0] = 12'hA5C;
    f_ones = '1;
    for (int i = 0; i < CFG_BITS; i++) f_alt[i] = (i % 2 == 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_select", cfg_if.select, '0);
    check("rst_ready", CFG_BITS'(cfg_if.cfg_ready), '0);
    check("rst_loaded", CFG_BITS'(cfg_if.cfg_loaded), '0);

    // Full frame, valid held high, with exact latency checks.
    d0 = done_cnt;
    cyc(1, 0, 0);
    check("ready_after_start", CFG_BITS'(cfg_if.cfg_ready), 1);
    send_bits(f_a5c, CFG_BITS, 0, 0);
`ifdef SB_CFG_PARITY_EN
    send_parity(f_a5c, 0);
`endif
    check("ready_after_last", CFG_BITS'(cfg_if.cfg_ready), 0);
    check("done_e1", CFG_BITS'(cfg_if.cfg_done), 0);
    cyc(0, 0, 0);
    check("done_e2", CFG_BITS'(cfg_if.cfg_done), 1);
    check("select_a5c", cfg_if.select, f_a5c);
    cyc(0, 0, 0);
    check("done_e3", CFG_BITS'(cfg_if.cfg_done), 0);
    check("loaded_a5c", CFG_BITS'(cfg_if.cfg_loaded), 1);
    finish_frame();
    check("done_cnt_full", CFG_BITS'(done_cnt - d0), 1);

    // Same frame with valid toggling; gap data is random.
    d0 = done_cnt;
    cyc(1, 0, 0);
    send_bits(f_a5c, CFG_BITS, 1, 0);
    send_parity(f_a5c, 0);
    finish_frame();
    check("select_stall", cfg_if.select, f_a5c);
    check("done_cnt_stall", CFG_BITS'(done_cnt - d0), 1);

    // Abort after 50 ones, then an all-zero frame.
    d0 = done_cnt;
    cyc(1, 0, 0);
    send_bits(f_ones, 50, 0, 0);
    cyc(1, 1, 1);
    send_bits('0, CFG_BITS, 0, 0);
    send_parity('0, 0);
    finish_frame();
    check("select_abort", cfg_if.select, '0);
    check("done_cnt_abort", CFG_BITS'(done_cnt - d0), 1);

    // Back-to-back: start during cfg_done is ignored.
    d0 = done_cnt;
    cyc(1, 0, 0);
    send_bits(f_ones, CFG_BITS, 0, 0);
    send_parity(f_ones, 0);
    cyc(0, 0, 0);
    check("b2b_done", CFG_BITS'(cfg_if.cfg_done), 1);
    cyc(1, 0, 0);
    check("b2b_ready_ignored", CFG_BITS'(cfg_if.cfg_ready), 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    send_bits(f_alt, CFG_BITS, 0, 0);
    send_parity(f_alt, 0);
    finish_frame();
    check("select_b2b", cfg_if.select, f_alt);
    check("done_cnt_b2b", CFG_BITS'(done_cnt - d0), 2);

`ifdef SB_CFG_PARITY_EN
    // Parity: good frame commits, flipped parity is rejected.
    cyc(1, 0, 0);
    send_bits(f_a5c, CFG_BITS, 0, 0);
    send_parity(f_a5c, 0);
    finish_frame();
    check("par_good_select", cfg_if.select, f_a5c);
    d0 = done_cnt;
    f_oth = '0; f_oth[0] = 1'b1;
    cyc(1, 0, 0);
    send_bits(f_oth, CFG_BITS, 0, 0);
    send_parity(f_oth, 1);
    repeat (3) cyc(0, 0, 0);
    check("par_bad_error", CFG_BITS'(cfg_if.cfg_error), 1);
    check("par_bad_select", cfg_if.select, f_a5c);
    check("par_bad_done", CFG_BITS'(done_cnt - d0), 0);
    cyc(1, 0, 0);
    check("par_err_clear", CFG_BITS'(cfg_if.cfg_error), 0);
    send_bits(f_alt, CFG_BITS, 0, 0);
    send_parity(f_alt, 0);
    finish_frame();
`endif

    // Asynchronous reset in the middle of a frame.
    cyc(1, 0, 0);
    send_bits(f_ones, 40, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_select", cfg_if.select, '0);
    check("arst_ready", CFG_BITS'(cfg_if.cfg_ready), '0);
    check("arst_done", CFG_BITS'(cfg_if.cfg_done), '0);
    check("arst_error", CFG_BITS'(cfg_if.cfg_error), '0);
    check("arst_loaded", CFG_BITS'(cfg_if.cfg_loaded), '0);
    cfg_if.cfg_valid = 0;
    cfg_if.cfg_start = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0);

    // Randomized frames with gaps, aborts, parity flips and starts during commit.
    for (int it = 0; it < 25; it++) begin
      int gp;
      gp = $urandom_range(0, 60);
      for (int i = 0; i < CFG_BITS; i++) begin
        f_rnd[i] = 1'($urandom_range(0, 1));
        f_oth[i] = 1'($urandom_range(0, 1));
      end
      cyc(1, 0, 0);
      if ($urandom_range(0, 99) < 30) begin
        send_bits(f_oth, $urandom_range(1, CFG_BITS - 1), 2, gp);
        cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      send_bits(f_rnd, CFG_BITS, 2, gp);
      send_parity(f_rnd, ($urandom_range(0, 99) < 25));
      if ($urandom_range(0, 99) < 30) begin
        cyc(0, 0, 0);
        cyc(1, 0, 0);
      end
      finish_frame();
    end
    repeat (3) cyc(0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
